// File: rtl/hvac_pkg.sv
// Shared types and defaults for the HVAC zone arbiter.
// Optional statistics counter is enabled by defining HVAC_ARB_STATS_EN.
package hvac_pkg;

  localparam int NUM_ZONES     = 4;
  localparam int MIN_ON_DEF    = 8;
  localparam int MAX_ON_DEF    = 32;
  localparam int DEAD_TIME_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  typedef enum logic {
    MODE_HEAT = 1'b0,
    MODE_COOL = 1'b1
  } mode_t;

  function automatic logic [NUM_ZONES-1:0] zone_onehot(input logic [1:0] zone);
    return 4'b0001 << zone;
  endfunction

endpackage

// File: rtl/hvac_zone_arbiter_if.sv
// Request/grant bundle between the zone thermostats and the arbiter.
// The master side drives the requests; the slave side (arbiter) drives the enables.
interface hvac_zone_arbiter_if;
  import hvac_pkg::*;

  logic [NUM_ZONES-1:0] heat_req;
  logic [NUM_ZONES-1:0] cool_req;
  logic                 heat_on;
  logic                 cool_on;
  logic [NUM_ZONES-1:0] zone_valve;
  logic [1:0]           grant_zone;
  logic                 busy;

  modport master (
    output heat_req, cool_req,
    input  heat_on, cool_on, zone_valve, grant_zone, busy
  );

  modport slave (
    input  heat_req, cool_req,
    output heat_on, cool_on, zone_valve, grant_zone, busy
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four zones.
// Search starts at last+1 and wraps around to last itself.
module rr_pick4 (
  input  logic [3:0] valid,
  input  logic [1:0] last,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] hit;
  logic [1:0] cand [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_order
      assign cand[gi] = last + 2'(gi + 1);
      assign hit[gi]  = valid[cand[gi]];
    end
  endgenerate

  // Lowest search offset wins; scan from the far end so the nearest hit overwrites.
  always_comb begin
    found = |hit;
    idx   = cand[3];
    for (int k = 3; k >= 0; k--) begin
      if (hit[k]) idx = cand[k];
    end
  end

endmodule

// File: rtl/hvac_zone_arbiter.sv
// Grants the shared heater/compressor to one zone at a time with min/max on-time and dead time.
// Define HVAC_ARB_STATS_EN to add the 16-bit saturating grant_count output.
module hvac_zone_arbiter
  import hvac_pkg::*;
#(
  parameter int MIN_ON    = MIN_ON_DEF,
  parameter int MAX_ON    = MAX_ON_DEF,
  parameter int DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  hvac_zone_arbiter_if.slave   bus
`ifdef HVAC_ARB_STATS_EN
  ,
  output logic [15:0]          grant_count
`endif
);

  localparam logic [7:0] MIN_ON_C    = 8'(MIN_ON);
  localparam logic [7:0] MAX_ON_C    = 8'(MAX_ON);
  localparam logic [7:0] DEAD_TIME_C = 8'(DEAD_TIME);

  state_t               state_reg, state_next;
  mode_t                mode_reg, mode_next;
  logic [7:0]           run_cnt_reg, run_cnt_next;
  logic [7:0]           dead_cnt_reg, dead_cnt_next;
  logic [1:0]           last_grant_reg, last_grant_next;
  logic [1:0]           grant_zone_reg, grant_zone_next;
  logic                 heat_on_reg, cool_on_reg, busy_reg;
  logic [NUM_ZONES-1:0] zone_valve_reg;

  logic [NUM_ZONES-1:0] valid;
  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic                 own_valid;
  logic                 others_valid;

  // A zone asking for both heat and cool at once is treated as not asking.
  assign valid = bus.heat_req ^ bus.cool_req;

  assign own_valid = (mode_reg == MODE_HEAT)
                   ? (bus.heat_req[grant_zone_reg] & ~bus.cool_req[grant_zone_reg])
                   : (bus.cool_req[grant_zone_reg] & ~bus.heat_req[grant_zone_reg]);
  assign others_valid = |(valid & ~zone_onehot(grant_zone_reg));

  rr_pick4 u_pick (
    .valid (valid),
    .last  (last_grant_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    run_cnt_next    = run_cnt_reg;
    dead_cnt_next   = dead_cnt_reg;
    last_grant_next = last_grant_reg;
    grant_zone_next = grant_zone_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          state_next      = ST_RUN;
          mode_next       = bus.heat_req[pick_idx] ? MODE_HEAT : MODE_COOL;
          run_cnt_next    = 8'd1;
          grant_zone_next = pick_idx;
          last_grant_next = pick_idx;
        end
      end
      ST_RUN: begin
        run_cnt_next = (run_cnt_reg == 8'hFF) ? run_cnt_reg : run_cnt_reg + 8'd1;
        if (((run_cnt_reg >= MIN_ON_C) && !own_valid) ||
            ((run_cnt_reg >= MAX_ON_C) && others_valid)) begin
          state_next    = ST_DEAD;
          dead_cnt_next = 8'd1;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_reg >= DEAD_TIME_C) begin
          state_next    = ST_IDLE;
          dead_cnt_next = 8'd0;
        end else begin
          dead_cnt_next = dead_cnt_reg + 8'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= MODE_HEAT;
      run_cnt_reg    <= 8'd0;
      dead_cnt_reg   <= 8'd0;
      last_grant_reg <= 2'd3;
      grant_zone_reg <= 2'd0;
      heat_on_reg    <= 1'b0;
      cool_on_reg    <= 1'b0;
      zone_valve_reg <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      run_cnt_reg    <= run_cnt_next;
      dead_cnt_reg   <= dead_cnt_next;
      last_grant_reg <= last_grant_next;
      grant_zone_reg <= grant_zone_next;
      heat_on_reg    <= (state_next == ST_RUN) && (mode_next == MODE_HEAT);
      cool_on_reg    <= (state_next == ST_RUN) && (mode_next == MODE_COOL);
      zone_valve_reg <= (state_next == ST_RUN) ? zone_onehot(grant_zone_next) : '0;
      busy_reg       <= (state_next != ST_IDLE);
    end
  end

  assign bus.heat_on    = heat_on_reg;
  assign bus.cool_on    = cool_on_reg;
  assign bus.zone_valve = zone_valve_reg;
  assign bus.grant_zone = grant_zone_reg;
  assign bus.busy       = busy_reg;

`ifdef HVAC_ARB_STATS_EN
  logic [15:0] grant_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count_reg <= 16'd0;
    end else if ((state_reg == ST_IDLE) && (state_next == ST_RUN) &&
                 (grant_count_reg != 16'hFFFF)) begin
      grant_count_reg <= grant_count_reg + 16'd1;
    end
  end

  assign grant_count = grant_count_reg;
`endif

endmodule

// File: doc/hvac_zone_arbiter.md
HVAC_ZONE_ARBITER -- requirements
Module: hvac_zone_arbiter

Interface
REQ-001 Parameter MIN_ON, default 8: minimum cycles a grant is held once issued (legal range 1..255).
REQ-002 Parameter MAX_ON, default 32: cycles after which a grant is pre-empted if another zone is waiting (MIN_ON..255).
REQ-003 Parameter DEAD_TIME, default 4: cycles of all-off between consecutive grants (1..255).
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 heat_req  in  4  per-zone heating request, bit i = zone i.
REQ-007 cool_req  in  4  per-zone cooling request, bit i = zone i.
REQ-008 heat_on  out  1  shared heater enable, registered.
REQ-009 cool_on  out  1  shared compressor enable, registered.
REQ-010 zone_valve  out  4  one-hot damper open for the granted zone, zero otherwise, registered.
REQ-011 grant_zone  out  2  index of the granted zone; holds its last value when not in RUN.
REQ-012 busy  out  1  high in RUN and DEAD.

Function
REQ-013 Zone i has a valid request when exactly one of heat_req[i]/cool_req[i] is high; when both are high, the zone is ignored.
REQ-014 States: IDLE, RUN, DEAD; all outputs derive from registered state.
REQ-015 IDLE: at the edge where any zone is valid, select a winner round-robin, set the mode from its request, and enter RUN with run_cnt=1.
REQ-016 Round-robin order starts at last_grant+1 mod 4 and ends at last_grant; last_grant updates on each RUN entry.
REQ-017 RUN: exactly one of heat_on/cool_on is high, matching the latched mode; zone_valve is the one-hot of grant_zone; run_cnt increments per cycle, saturating at 255.
REQ-018 RUN exits to DEAD at the edge where run_cnt>=MIN_ON and the granted zone is no longer valid in the latched mode (dropped, reversed or conflicting).
REQ-019 RUN also exits to DEAD at the edge where run_cnt>=MAX_ON and any other zone is valid.
REQ-020 No exit occurs before MIN_ON cycles, even if the request drops.
REQ-021 DEAD: heat_on, cool_on and zone_valve are all 0; it lasts exactly DEAD_TIME cycles, then the block enters IDLE.
REQ-022 heat_on and cool_on are never high in the same cycle, and are never high in consecutive grants without an intervening DEAD period.
REQ-023 Request-to-grant latency from IDLE is one edge; IDLE with a valid request never persists more than one cycle.

Reset
REQ-024 On rst at any edge: state=IDLE, heat_on=0, cool_on=0, zone_valve=0, grant_zone=0, busy=0, run_cnt=0, last_grant=3 (zone 0 has first priority).
REQ-025 rst asserted mid-RUN or mid-DEAD aborts immediately; no DEAD period follows reset.

Configuration
REQ-026 With macro HVAC_ARB_STATS_EN defined, output grant_count (16 bits) exists.
REQ-027 grant_count increments on every IDLE->RUN transition, saturates at 65535, and clears on rst.
REQ-028 Without HVAC_ARB_STATS_EN, the port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Package hvac_pkg holds the state enum (IDLE/RUN/DEAD), the mode enum (HEAT/COOL), NUM_ZONES=4, and the parameter defaults.
REQ-030 Sub-module rr_pick4 is the combinational round-robin picker (inputs: valid[3:0], last[1:0]; outputs: found, idx[1:0]).

Verification (MIN_ON=8, MAX_ON=32, DEAD_TIME=4)
REQ-031 Reset: heat_req=4'b0001 held -> heat_on=1, zone_valve=4'b0001 one edge after rst deasserts; rst high mid-RUN -> all outputs 0 at next edge.
REQ-032 Minimum on: cool_req[2] pulses for 2 cycles -> cool_on high for exactly 8 cycles, then 4 cycles all-off, busy high for 12 cycles total.
REQ-033 Pre-emption: heat_req=4'b0011 held -> zone 0 granted for 32 cycles, 4 DEAD cycles, then zone 1 for 32 cycles, then zone 0 again.
REQ-034 Mode change: zone 1 heating, then heat_req[1]=0 and cool_req[3]=1 -> heat_on falls, 4 DEAD cycles follow, then cool_on=1 with zone_valve=4'b1000; the heat/cool overlap assertion never fires.
REQ-035 Conflict: heat_req=cool_req=4'b0100 -> no grant, busy=0; then cool_req[2]=0 -> heat grant to zone 2 at the next edge.
REQ-036 With HVAC_ARB_STATS_EN: 3 separate grants -> grant_count=3; after rst, grant_count=0.
